// File: rtl/wb_ctrl.sv
// Write-back controller: arbitrates ALU and load results onto the single
// register-file write port, holds one deferred ALU result in a skid buffer
// and tracks outstanding destination writes for the issue stage.
module wb_ctrl #(
  parameter int DW           = 32,
  parameter int AW           = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 alu_valid,
  output logic                 alu_ready,
  input  logic [AW-1:0]        alu_rd,
  input  logic [DW-1:0]        alu_data,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [AW-1:0]        ld_rd,
  input  logic [DW-1:0]        ld_data,
  input  logic                 iss_valid,
  input  logic [AW-1:0]        iss_rd,
  output logic                 iss_stall,
  output logic [(1<<AW)-1:0]   pending,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_ad,
  output logic [DW-1:0]        wr_data
);

  localparam int NR = 1 << AW;
  localparam int CW = 4;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {SRC_NONE, SRC_SKID, SRC_LD, SRC_ALU} src_t;

  logic          skid_full;
  logic [AW-1:0] skid_rd;
  logic [DW-1:0] skid_data;
  logic [CW-1:0] starve_cnt;

  src_t          src;
  logic          starved;
  logic          alu_to_skid;
  logic [AW-1:0] sel_rd;
  logic [DW-1:0] sel_data;
  logic [NR-1:0] clr_mask;
  logic [NR-1:0] set_mask;

  assign starved     = skid_full && (starve_cnt == LIMIT);
  assign ld_ready    = !starved;
  assign alu_ready   = !skid_full || (src == SRC_SKID);
  // An accepted ALU result that does not go straight to the port is parked.
  assign alu_to_skid = alu_valid && alu_ready && (src != SRC_ALU);
  assign iss_stall   = iss_valid && pending[iss_rd];

  // Pick this cycle's write source in fixed priority and mux its payload.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no latch is inferred.
    src      = SRC_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (starved)        src = SRC_SKID;
    else if (ld_valid)  src = SRC_LD;
    else if (skid_full) src = SRC_SKID;
    else if (alu_valid) src = SRC_ALU;
    case (src)
      SRC_SKID: begin sel_rd = skid_rd; sel_data = skid_data; end
      SRC_LD:   begin sel_rd = ld_rd;   sel_data = ld_data;   end
      SRC_ALU:  begin sel_rd = alu_rd;  sel_data = alu_data;  end
      default:  ;
    endcase
  end

  // Scoreboard masks: clear on the write being registered, set on accepted claim.
  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (src != SRC_NONE)         clr_mask = NR'(1) << sel_rd;
    if (iss_valid && !iss_stall) set_mask = NR'(1) << iss_rd;
  end

  // Registered write port; address and data hold while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
      wr_en   <= 1'b0;
      wr_ad   <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= (src != SRC_NONE);
      if (src != SRC_NONE) begin
        wr_ad   <= sel_rd;
        wr_data <= sel_data;
      end
    end
  end

  // One-entry skid buffer: refill wins over drain in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_full <= 1'b0;
      skid_rd   <= '0;
      skid_data <= '0;
    end else if (alu_to_skid) begin
      skid_full <= 1'b1;
      skid_rd   <= alu_rd;
      skid_data <= alu_data;
    end else if (src == SRC_SKID) begin
      skid_full <= 1'b0;
    end
  end

  // Count cycles the held result loses; clear on drain, saturate at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   starve_cnt <= '0;
    else if (src == SRC_SKID)                     starve_cnt <= '0;
    else if (skid_full && starve_cnt != LIMIT)    starve_cnt <= starve_cnt + 1'b1;
  end

  // Pending-write scoreboard; a new claim overrides a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | set_mask;
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// Bench for wb_ctrl: expected writes are queued when stimulus is driven and
// popped by a monitor whenever the write port fires.
module tb_wb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid, iss_valid;
  logic        alu_ready, ld_ready, iss_stall;
  logic [3:0]  alu_rd, ld_rd, iss_rd, wr_ad;
  logic [31:0] alu_data, ld_data, wr_data;
  logic [15:0] pending;
  logic        wr_en;

  typedef struct packed {
    logic [3:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;

  wb_ctrl #(.DW(32), .AW(4), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_stall(iss_stall), .pending(pending),
    .wr_en(wr_en), .wr_ad(wr_ad), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic av, input logic [3:0] ard, input logic [31:0] ad,
                       input logic lv, input logic [3:0] lrd, input logic [31:0] ld,
                       input logic iv, input logic [3:0] ird);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    ld_valid  = lv; ld_rd  = lrd; ld_data  = ld;
    iss_valid = iv; iss_rd = ird;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expect_wr(input logic [3:0] rd, input logic [31:0] data);
    wr_t w;
    w.rd = rd; w.data = data;
    exp_q.push_back(w);
  endtask

  // Monitor: every write pulse must match the oldest expected write.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {28'd0, wr_ad, wr_data}, 64'd0);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("write", {28'd0, wr_ad, wr_data}, {28'd0, w.rd, w.data});
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle();
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_ad", wr_ad, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_pending", pending, 0);
    check("rst_alu_ready", alu_ready, 1);
    check("rst_ld_ready", ld_ready, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single ALU write, one-cycle latency, one-cycle pulse, held address.
    drive(1'b1, 4'd3, 32'hDEADBEEF, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    check("single_alu_ready", alu_ready, 1);
    expect_wr(4'd3, 32'hDEADBEEF);
    step();
    check("single_wr_en_c1", wr_en, 1);
    idle();
    step();
    check("single_wr_en_c2", wr_en, 0);
    check("single_wr_ad_hold", wr_ad, 3);

    // Collision: load wins, ALU parked in skid and written next.
    drive(1'b1, 4'd6, 32'd2, 1'b1, 4'd5, 32'd1, 1'b0, 4'd0);
    check("coll_alu_ready", alu_ready, 1);
    check("coll_ld_ready", ld_ready, 1);
    expect_wr(4'd5, 32'd1);
    expect_wr(4'd6, 32'd2);
    step();
    idle();
    step();
    step();

    // Skid full: second ALU result blocked, then accepted as the skid drains.
    drive(1'b1, 4'd9, 32'd11, 1'b1, 4'd8, 32'd10, 1'b0, 4'd0);
    expect_wr(4'd8, 32'd10);
    step();
    drive(1'b1, 4'd11, 32'd13, 1'b1, 4'd10, 32'd12, 1'b0, 4'd0);
    check("skid_alu_ready_blocked", alu_ready, 0);
    expect_wr(4'd10, 32'd12);
    step();
    drive(1'b1, 4'd11, 32'd13, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    check("skid_alu_ready_drain", alu_ready, 1);
    expect_wr(4'd9, 32'd11);
    expect_wr(4'd11, 32'd13);
    step();
    idle();
    step();
    step();

    // Starvation: four lost cycles, then the skid takes priority over the load.
    drive(1'b1, 4'd2, 32'd200, 1'b1, 4'd1, 32'd100, 1'b0, 4'd0);
    expect_wr(4'd1, 32'd100);
    step();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 32'd100 + i, 1'b0, 4'd0);
      check("starve_ld_ready_open", ld_ready, 1);
      expect_wr(4'd1, 32'd100 + i);
      step();
    end
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 32'd105, 1'b0, 4'd0);
    check("starve_ld_ready_closed", ld_ready, 0);
    expect_wr(4'd2, 32'd200);
    step();
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd1, 32'd105, 1'b0, 4'd0);
    check("starve_ld_ready_reopen", ld_ready, 1);
    expect_wr(4'd1, 32'd105);
    step();
    idle();
    step();

    // Scoreboard: claim, refused reclaim, clear on write, set wins over clear.
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7);
    check("sb_first_claim_stall", iss_stall, 0);
    step();
    check("sb_pending_set", pending, 16'h0080);
    drive(1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 4'd7);
    check("sb_second_claim_stall", iss_stall, 1);
    step();
    check("sb_pending_kept", pending, 16'h0080);
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'd77, 1'b0, 4'd0);
    expect_wr(4'd7, 32'd77);
    step();
    check("sb_pending_cleared", pending, 16'h0000);
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd7, 32'd78, 1'b1, 4'd7);
    check("sb_claim_with_write_stall", iss_stall, 0);
    expect_wr(4'd7, 32'd78);
    step();
    check("sb_set_wins", pending, 16'h0080);
    drive(1'b1, 4'd7, 32'd79, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
    expect_wr(4'd7, 32'd79);
    step();
    check("sb_alu_clear", pending, 16'h0000);
    idle();
    step();

    // Mid-cycle reset with skid full and r0/r5 pending discards everything.
    drive(1'b1, 4'd13, 32'd130, 1'b1, 4'd12, 32'd120, 1'b1, 4'd0);
    expect_wr(4'd12, 32'd120);
    step();
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd14, 32'd140, 1'b1, 4'd5);
    expect_wr(4'd14, 32'd140);
    step();
    drive(1'b0, 4'd0, 32'd0, 1'b1, 4'd15, 32'd150, 1'b0, 4'd0);
    check("pre_rst_pending", pending, 16'h0021);
    check("pre_rst_alu_ready", alu_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_wr_en", wr_en, 0);
    check("async_rst_pending", pending, 0);
    check("async_rst_alu_ready", alu_ready, 1);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step();
    check("no_stale_write_wr_en", wr_en, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
